// File: rtl/map_page_viewer.sv
// map_page_viewer: selects one row ("page") of a flattened walkable-map bitmap
// for LED display. Pages step manually (up/down pulses, wrap-around) or
// automatically (one down-step every AUTO_PERIOD clk1hz ticks in AUTO).
// Optional feature macro: VIEW_SNAPSHOT_EN -- when defined, row_bits is a
// register reloaded only on page change, on snap, and on the cycle after
// reset, so a live map does not flicker the LEDs.
module map_page_viewer #(
    parameter int ROW_W       = 10,
    parameter int NUM_ROWS    = 6,
    parameter int PAGE_W      = 4,
    parameter int AUTO_PERIOD = 3
) (
    input  logic                      clk1hz,
    input  logic                      rst,
    input  logic                      up_pulse,
    input  logic                      down_pulse,
    input  logic                      auto_toggle,
    input  logic                      snap,
    input  logic [ROW_W*NUM_ROWS-1:0] map_flat,
    output logic [PAGE_W-1:0]         page_idx,
    output logic [ROW_W-1:0]          row_bits,
    output logic                      auto_active,
    output logic                      page_changed,
    output logic                      wrap_pulse
);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_ROWS - 1);
    localparam logic [7:0]        TICK_LAST = 8'(AUTO_PERIOD - 1);

    state_t            state;
    state_t            state_next;
    logic [7:0]        tick_cnt;
    logic [7:0]        tick_next;
    logic [PAGE_W-1:0] idx_next;
    logic              step_up;
    logic              step_down;
    logic              wrap_next;

    // Row lookup by matching against every legal page; anything unmatched
    // falls back to row 0, so a misconfigured index can never read past the map.
    function automatic logic [ROW_W-1:0] select_row(
        input logic [ROW_W*NUM_ROWS-1:0] map,
        input logic [PAGE_W-1:0]         page
    );
        logic [ROW_W-1:0] row;
        row = map[ROW_W-1:0];
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (page == PAGE_W'(r)) row = map[r*ROW_W +: ROW_W];
        end
        return row;
    endfunction

    // State register, page index, scan counter and one-cycle status pulses.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk1hz) begin
        if (rst) begin
            state        <= MANUAL;
            tick_cnt     <= '0;
            page_idx     <= '0;
            page_changed <= 1'b0;
            wrap_pulse   <= 1'b0;
        end else begin
            state        <= state_next;
            tick_cnt     <= tick_next;
            page_idx     <= idx_next;
            page_changed <= (idx_next != page_idx);
            wrap_pulse   <= wrap_next;
        end
    end

    // Next-state, scan counter and step decision.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        step_up    = up_pulse & ~down_pulse;
        step_down  = down_pulse & ~up_pulse;
        wrap_next  = 1'b0;
        idx_next   = page_idx;

        case (state)
            MANUAL: begin
                // Counter is held at zero so AUTO always starts a full period.
                tick_next = '0;
                if (auto_toggle) state_next = AUTO;
            end
            AUTO: begin
                // Any manual interaction, including toggle plus step or
                // up and down together, leaves AUTO; no double toggle.
                if (auto_toggle || up_pulse || down_pulse) begin
                    state_next = MANUAL;
                    tick_next  = '0;
                end else if (tick_cnt == TICK_LAST) begin
                    tick_next = '0;
                    step_down = 1'b1;
                end else begin
                    tick_next = tick_cnt + 8'd1;
                end
            end
            default: state_next = MANUAL;
        endcase

        if (step_up) begin
            if (page_idx == '0) begin
                idx_next  = LAST_PAGE;
                wrap_next = 1'b1;
            end else begin
                idx_next = page_idx - 1'b1;
            end
        end else if (step_down) begin
            if (page_idx == LAST_PAGE) begin
                idx_next  = '0;
                wrap_next = 1'b1;
            end else begin
                idx_next = page_idx + 1'b1;
            end
        end
    end

    assign auto_active = (state == AUTO);

`ifdef VIEW_SNAPSHOT_EN
    logic load_pending;

    // Snapshot register: reload from the newly selected row on page change,
    // on snap, and once right after reset; otherwise hold.
    always_ff @(posedge clk1hz) begin
        if (rst) begin
            row_bits     <= '0;
            load_pending <= 1'b1;
        end else begin
            load_pending <= 1'b0;
            if (load_pending || snap || (idx_next != page_idx)) begin
                row_bits <= select_row(map_flat, idx_next);
            end
        end
    end
`else
    logic unused_snap;

    // Live view: the current page's row, zero latency; snap has no effect.
    always_comb begin
        row_bits    = select_row(map_flat, page_idx);
        unused_snap = snap;
    end
`endif

endmodule

// File: tb/tb_map_page_viewer.sv
// Self-checking bench for map_page_viewer: a table of stimulus/expected
// records is applied one clk1hz cycle each; expectations are queued when the
// stimulus is driven and popped and compared after the clock edge.
module tb_map_page_viewer;

    localparam int ROW_W    = 10;
    localparam int NUM_ROWS = 6;
    localparam int PAGE_W   = 4;

`ifdef VIEW_SNAPSHOT_EN
    localparam bit SNAPSHOT = 1'b1;
`else
    localparam bit SNAPSHOT = 1'b0;
`endif

    typedef struct {
        logic              rst;
        logic              up;
        logic              down;
        logic              tog;
        logic              snap;
        logic [PAGE_W-1:0] idx;
        logic              act;
        logic              chg;
        logic              wrap;
    } vec_t;

    typedef struct {
        string             name;
        logic [PAGE_W-1:0] idx;
        logic [ROW_W-1:0]  row;
        logic              act;
        logic              chg;
        logic              wrap;
    } exp_t;

    logic                      clk1hz = 1'b0;
    logic                      rst = 1'b0;
    logic                      up_pulse = 1'b0;
    logic                      down_pulse = 1'b0;
    logic                      auto_toggle = 1'b0;
    logic                      snap = 1'b0;
    logic [ROW_W*NUM_ROWS-1:0] map_flat;
    logic [PAGE_W-1:0]         page_idx;
    logic [ROW_W-1:0]          row_bits;
    logic                      auto_active;
    logic                      page_changed;
    logic                      wrap_pulse;

    logic [ROW_W-1:0] map_rows [NUM_ROWS];
    vec_t             vecs[$];
    exp_t             sb[$];
    int               checks = 0;
    int               passes = 0;

    map_page_viewer #(
        .ROW_W      (ROW_W),
        .NUM_ROWS   (NUM_ROWS),
        .PAGE_W     (PAGE_W),
        .AUTO_PERIOD(3)
    ) dut (
        .clk1hz      (clk1hz),
        .rst         (rst),
        .up_pulse    (up_pulse),
        .down_pulse  (down_pulse),
        .auto_toggle (auto_toggle),
        .snap        (snap),
        .map_flat    (map_flat),
        .page_idx    (page_idx),
        .row_bits    (row_bits),
        .auto_active (auto_active),
        .page_changed(page_changed),
        .wrap_pulse  (wrap_pulse)
    );

    always #5 clk1hz = ~clk1hz;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic load_map();
        for (int r = 0; r < NUM_ROWS; r++) map_flat[r*ROW_W +: ROW_W] = map_rows[r];
    endtask

    task automatic add(input logic r, input logic u, input logic d, input logic t, input logic s,
                       input int idx, input logic act, input logic chg, input logic wrap);
        vec_t v;
        v.rst = r; v.up = u; v.down = d; v.tog = t; v.snap = s;
        v.idx = PAGE_W'(idx); v.act = act; v.chg = chg; v.wrap = wrap;
        vecs.push_back(v);
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs.
    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL scoreboard: empty on compare");
            return;
        end
        e = sb.pop_front();
        check({e.name, " page_idx"},     32'(page_idx),     32'(e.idx));
        check({e.name, " row_bits"},     32'(row_bits),     32'(e.row));
        check({e.name, " auto_active"},  32'(auto_active),  32'(e.act));
        check({e.name, " page_changed"}, 32'(page_changed), 32'(e.chg));
        check({e.name, " wrap_pulse"},   32'(wrap_pulse),   32'(e.wrap));
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input string name, input vec_t v, input logic [ROW_W-1:0] exp_row);
        exp_t e;
        rst = v.rst; up_pulse = v.up; down_pulse = v.down;
        auto_toggle = v.tog; snap = v.snap;
        e.name = name; e.idx = v.idx; e.row = exp_row;
        e.act = v.act; e.chg = v.chg; e.wrap = v.wrap;
        sb.push_back(e);
        @(posedge clk1hz);
        #1;
        compare_front();
    endtask

    initial begin
        vec_t             v;
        logic [ROW_W-1:0] exp_row;
        logic [ROW_W-1:0] old_row;

        map_rows[0] = 10'h2A5; map_rows[1] = 10'h15A; map_rows[2] = 10'h0F0;
        map_rows[3] = 10'h30F; map_rows[4] = 10'h3C3; map_rows[5] = 10'h03C;
        load_map();

        //   rst up dn tog snap  idx act chg wrap
        add(1, 0, 0, 0, 0,   0, 0, 0, 0);   // reset, two cycles
        add(1, 0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 1, 0, 0, 0,   5, 0, 1, 1);   // up at 0 wraps to last
        add(0, 0, 0, 0, 0,   5, 0, 0, 0);   // pulses last one cycle
        add(0, 0, 1, 0, 0,   0, 0, 1, 1);   // down at last wraps to 0
        add(0, 0, 1, 0, 0,   1, 0, 1, 0);
        add(0, 0, 1, 0, 0,   2, 0, 1, 0);
        add(0, 0, 1, 0, 0,   3, 0, 1, 0);
        add(0, 0, 1, 0, 0,   4, 0, 1, 0);
        add(0, 0, 1, 0, 0,   5, 0, 1, 0);
        add(0, 0, 1, 0, 0,   0, 0, 1, 1);
        add(0, 0, 1, 0, 0,   1, 0, 1, 0);
        add(0, 0, 1, 0, 0,   2, 0, 1, 0);
        add(0, 1, 1, 0, 0,   2, 0, 0, 0);   // up+down together: no step
        add(0, 0, 0, 1, 0,   2, 1, 0, 0);   // enter AUTO
        add(0, 0, 0, 0, 0,   2, 1, 0, 0);
        add(0, 0, 0, 0, 0,   2, 1, 0, 0);
        add(0, 0, 0, 0, 0,   3, 1, 1, 0);   // third tick steps
        add(0, 0, 0, 0, 0,   3, 1, 0, 0);
        add(0, 1, 0, 0, 0,   2, 0, 1, 0);   // up mid-scan: step and exit
        add(0, 0, 0, 0, 0,   2, 0, 0, 0);
        add(0, 0, 1, 1, 0,   3, 1, 1, 0);   // MANUAL: toggle+down
        add(0, 1, 0, 1, 0,   2, 0, 1, 0);   // AUTO: toggle+up ends MANUAL
        add(0, 0, 0, 1, 0,   2, 1, 0, 0);
        add(0, 1, 1, 0, 0,   2, 0, 0, 0);   // AUTO: up+down exits, no step
        add(0, 0, 0, 1, 0,   2, 1, 0, 0);   // auto scan through the wrap
        add(0, 0, 0, 0, 0,   2, 1, 0, 0);
        add(0, 0, 0, 0, 0,   2, 1, 0, 0);
        add(0, 0, 0, 0, 0,   3, 1, 1, 0);
        add(0, 0, 0, 0, 0,   3, 1, 0, 0);
        add(0, 0, 0, 0, 0,   3, 1, 0, 0);
        add(0, 0, 0, 0, 0,   4, 1, 1, 0);
        add(0, 0, 0, 0, 0,   4, 1, 0, 0);
        add(0, 0, 0, 0, 0,   4, 1, 0, 0);
        add(0, 0, 0, 0, 0,   5, 1, 1, 0);
        add(0, 0, 0, 0, 0,   5, 1, 0, 0);
        add(0, 0, 0, 0, 0,   5, 1, 0, 0);
        add(0, 0, 0, 0, 0,   0, 1, 1, 1);
        add(1, 0, 1, 1, 0,   0, 0, 0, 0);   // reset dominates
        add(0, 1, 0, 0, 0,   5, 0, 1, 1);
        add(0, 0, 1, 0, 0,   0, 0, 1, 1);
        add(0, 0, 0, 1, 0,   0, 1, 0, 0);   // AUTO from page 0
        add(0, 0, 0, 0, 0,   0, 1, 0, 0);
        add(0, 0, 0, 0, 0,   0, 1, 0, 0);
        add(0, 0, 0, 0, 0,   1, 1, 1, 0);
        add(0, 0, 0, 1, 0,   1, 0, 0, 0);   // toggle alone exits AUTO
        add(0, 1, 0, 0, 0,   0, 0, 1, 0);
        add(0, 0, 0, 0, 1,   0, 0, 0, 0);   // snap on unchanged map

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            exp_row = (SNAPSHOT && v.rst) ? '0 : map_rows[v.idx];
            apply($sformatf("vec%0d", i), v, exp_row);
        end

        // Live-map change on the displayed page 0, then snap.
        old_row = map_rows[0];
        map_rows[0] = 10'h1E7;
        load_map();
        #1;
        check("map edit immediate row_bits", 32'(row_bits),
              SNAPSHOT ? 32'(old_row) : 32'(map_rows[0]));
        v = '{rst: 0, up: 0, down: 0, tog: 0, snap: 0, idx: 0, act: 0, chg: 0, wrap: 0};
        apply("map edit hold", v, SNAPSHOT ? old_row : map_rows[0]);
        v.snap = 1'b1;
        apply("snap capture", v, map_rows[0]);
        v.snap = 1'b0;
        v.down = 1'b1; v.idx = 1; v.chg = 1'b1;
        apply("step after snap", v, map_rows[1]);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
